sd_cmd_sequencer: RTL and testbench

SD_CMD_SEQUENCER -- requirements
Module: sd_cmd_sequencer

---
 rtl/sd_pkg.sv | 42 ++++
 rtl/sd_cmd_timer.sv | 51 +++++
 rtl/sd_cmd_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD command constants, encodings and sequencer states
package sd_pkg;

    // Command indices
    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD2   = 6'd2;
    localparam logic [5:0] CMD7   = 6'd7;
    localparam logic [5:0] CMD9   = 6'd9;
    localparam logic [5:0] CMD13  = 6'd13;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam logic [5:0] CMD55  = 6'd55;

    // Response type encodings (req_rtype)
    localparam logic [1:0] RT_NONE = 2'd0;
    localparam logic [1:0] RT_R1   = 2'd1;
    localparam logic [1:0] RT_R2   = 2'd2;
    localparam logic [1:0] RT_R3   = 2'd3;

    // Completion status codes
    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_CRC     = 3'd1;
    localparam logic [2:0] ST_TIMEOUT = 3'd2;
    localparam logic [2:0] ST_INDEX   = 3'd3;
    localparam logic [2:0] ST_CARD    = 3'd4;
    localparam logic [2:0] ST_APP     = 3'd5;
    localparam logic [2:0] ST_ABORT   = 3'd6;

    // R1 card-status bits that count as errors, and the APP_CMD flag position
    localparam logic [31:0] ERR_MASK_DEFAULT = 32'hFFF8_0008;
    localparam int          APP_CMD_BIT      = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APP_SEND,
        S_APP_WAIT,
        S_CMD_SEND,
        S_CMD_WAIT,
        S_CHECK,
        S_DONE
    } state_e;

endpackage

// File: rtl/sd_cmd_timer.sv
// rtl/sd_cmd_timer.sv - response timeout counter and retry counter
// Ports:
//   clk, reset              clock, async active-high reset
//   tmr_clr_i / tmr_run_i   restart / advance the response timeout counter
//   retry_clr_i/retry_inc_i clear / bump the retry counter
//   timeout_o               last allowed wait cycle passed without a response
//   retry_avail_o           another re-issue is permitted
//   retry_cnt_o             re-issues performed for the current request
module sd_cmd_timer #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tmr_clr_i,
    input  logic       tmr_run_i,
    input  logic       retry_clr_i,
    input  logic       retry_inc_i,
    output logic       timeout_o,
    output logic       retry_avail_o,
    output logic [1:0] retry_cnt_o
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmr_q;
    logic [1:0]    retry_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q   <= '0;
            retry_q <= '0;
        end else begin
            if (tmr_clr_i) begin
                tmr_q <= '0;
            end else if (tmr_run_i && !timeout_o) begin
                tmr_q <= tmr_q + 1'b1;
            end
            if (retry_clr_i) begin
                retry_q <= '0;
            end else if (retry_inc_i) begin
                retry_q <= retry_q + 1'b1;
            end
        end
    end

    // Counter is 0 on the first wait cycle, so the wait lasts exactly TIMEOUT_CYC cycles.
    assign timeout_o     = tmr_run_i && (tmr_q == TW'(TIMEOUT_CYC - 1));
    assign retry_avail_o = (32'(retry_q) < MAX_RETRY);
    assign retry_cnt_o   = retry_q;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// rtl/sd_cmd_sequencer.sv - SD command sequencer with CMD55 prefix, response check and retry
// Ports:
//   clk, reset                      clock, async active-high reset
//   abort                           synchronous abort of the current command
//   req_* / req_ready               command request handshake (index, arg, app prefix, rtype)
//   rca                             card address placed in the CMD55 argument
//   send_en / send_cmd_content      one-cycle send strobe and {index, arg} to the sender
//   sd_cmd_sending                  sender busy
//   receive_en / R2_response        response receiver enable and long-response select
//   sd_receive_finished, crc_response_err, response   receiver result
//   done / status                   completion pulse and result code
//   resp_out / card_status          last captured response and last R1 card status
//   retry_cnt                       re-issues used by the current/last request
module sd_cmd_sequencer
    import sd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [31:0] ERR_MASK    = ERR_MASK_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         abort,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [5:0]   req_index,
    input  logic [31:0]  req_arg,
    input  logic         req_app,
    input  logic [1:0]   req_rtype,
    input  logic [15:0]  rca,
    output logic         send_en,
    output logic [37:0]  send_cmd_content,
    input  logic         sd_cmd_sending,
    output logic         receive_en,
    output logic         R2_response,
    input  logic         sd_receive_finished,
    input  logic         crc_response_err,
    input  logic [126:0] response,
    output logic         done,
    output logic [2:0]   status,
    output logic [126:0] resp_out,
    output logic [31:0]  card_status,
    output logic [1:0]   retry_cnt
);
    state_e         state_q, state_d;
    logic [5:0]     idx_q;
    logic [31:0]    arg_q;
    logic           app_q;
    logic [1:0]     rtype_q;
    logic           phase_app_q;
    logic           crc_q;
    logic [5:0]     rsp_idx_q;
    logic [2:0]     status_q, status_d;
    logic [126:0]   resp_q;
    logic [31:0]    card_q;

    logic           accept, capture, retry_inc;
    logic           timeout, retry_avail, expect_rsp;
    logic           is_r1, crc_fail;
    logic [5:0]     exp_idx;
    state_e         retry_state;

    assign expect_rsp  = (state_q == S_APP_WAIT) ||
                         ((state_q == S_CMD_WAIT) && (rtype_q != RT_NONE));
    // CMD55 always answers R1, so the APP phase is checked like an R1 command.
    assign is_r1       = phase_app_q || (rtype_q == RT_R1);
    assign exp_idx     = phase_app_q ? CMD55 : idx_q;
    // R3 carries no valid CRC; a receiver CRC flag on it is meaningless.
    assign crc_fail    = crc_q && (phase_app_q || (rtype_q != RT_R3));
    assign retry_state = app_q ? S_APP_SEND : S_CMD_SEND;

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        accept    = 1'b0;
        capture   = 1'b0;
        retry_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = req_app ? S_APP_SEND : S_CMD_SEND;
                end
            end
            S_APP_SEND: state_d = S_APP_WAIT;
            S_CMD_SEND: state_d = S_CMD_WAIT;
            S_APP_WAIT, S_CMD_WAIT: begin
                if (!expect_rsp) begin
                    if (!sd_cmd_sending) begin
                        state_d  = S_DONE;
                        status_d = ST_OK;
                    end
                end else if (sd_receive_finished) begin
                    capture = 1'b1;
                    state_d = S_CHECK;
                end else if (timeout) begin
                    if (retry_avail) begin
                        retry_inc = 1'b1;
                        state_d   = retry_state;
                    end else begin
                        state_d  = S_DONE;
                        status_d = ST_TIMEOUT;
                    end
                end
            end
            S_CHECK: begin
                if (crc_fail) begin
                    if (retry_avail) begin
                        retry_inc = 1'b1;
                        state_d   = retry_state;
                    end else begin
                        state_d  = S_DONE;
                        status_d = ST_CRC;
                    end
                end else if (is_r1 && (rsp_idx_q != exp_idx)) begin
                    state_d  = S_DONE;
                    status_d = ST_INDEX;
                end else if (is_r1 && ((card_q & ERR_MASK) != 32'h0)) begin
                    state_d  = S_DONE;
                    status_d = ST_CARD;
                end else if (phase_app_q && !card_q[APP_CMD_BIT]) begin
                    state_d  = S_DONE;
                    status_d = ST_APP;
                end else if (phase_app_q) begin
                    state_d = S_CMD_SEND;
                end else begin
                    state_d  = S_DONE;
                    status_d = ST_OK;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything, including a response landing this cycle.
        if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d   = S_DONE;
            status_d  = ST_ABORT;
            capture   = 1'b0;
            retry_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            status_q    <= '0;
            idx_q       <= '0;
            arg_q       <= '0;
            app_q       <= 1'b0;
            rtype_q     <= '0;
            phase_app_q <= 1'b0;
            crc_q       <= 1'b0;
            rsp_idx_q   <= '0;
            resp_q      <= '0;
            card_q      <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            if (accept) begin
                idx_q   <= req_index;
                arg_q   <= req_arg;
                app_q   <= req_app;
                rtype_q <= req_rtype;
            end
            if (capture) begin
                resp_q      <= response;
                crc_q       <= crc_response_err;
                rsp_idx_q   <= response[125:120];
                phase_app_q <= (state_q == S_APP_WAIT);
                if ((state_q == S_APP_WAIT) || (rtype_q == RT_R1)) begin
                    card_q <= response[119:88];
                end
            end
        end
    end

    sd_cmd_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .MAX_RETRY   (MAX_RETRY)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .tmr_clr_i     (send_en),
        .tmr_run_i     (expect_rsp),
        .retry_clr_i   (accept),
        .retry_inc_i   (retry_inc),
        .timeout_o     (timeout),
        .retry_avail_o (retry_avail),
        .retry_cnt_o   (retry_cnt)
    );

    assign req_ready        = (state_q == S_IDLE);
    assign send_en          = (state_q == S_APP_SEND) || (state_q == S_CMD_SEND);
    assign send_cmd_content = (state_q == S_APP_SEND) ? {CMD55, rca, 16'h0000} :
                              (state_q == S_CMD_SEND) ? {idx_q, arg_q} : 38'h0;
    assign receive_en       = expect_rsp;
    assign R2_response      = (state_q == S_CMD_WAIT) && (rtype_q == RT_R2);
    assign done             = (state_q == S_DONE);
    assign status           = status_q;
    assign resp_out         = resp_q;
    assign card_status      = card_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb/tb_sd_cmd_sequencer.sv - directed scoreboard bench for sd_cmd_sequencer
module tb_sd_cmd_sequencer;
    import sd_pkg::*;

    localparam int TO    = 64;
    localparam int LIMIT = 400;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         abort = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [5:0]   req_index = '0;
    logic [31:0]  req_arg = '0;
    logic         req_app = 1'b0;
    logic [1:0]   req_rtype = '0;
    logic [15:0]  rca = '0;
    logic         send_en;
    logic [37:0]  send_cmd_content;
    logic         sd_cmd_sending = 1'b0;
    logic         receive_en;
    logic         R2_response;
    logic         sd_receive_finished = 1'b0;
    logic         crc_response_err = 1'b0;
    logic [126:0] response = '0;
    logic         done;
    logic [2:0]   status;
    logic [126:0] resp_out;
    logic [31:0]  card_status;
    logic [1:0]   retry_cnt;

    sd_cmd_sequencer #(
        .TIMEOUT_CYC (TO),
        .MAX_RETRY   (3),
        .ERR_MASK    (32'hFFF8_0008)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .abort               (abort),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_index           (req_index),
        .req_arg             (req_arg),
        .req_app             (req_app),
        .req_rtype           (req_rtype),
        .rca                 (rca),
        .send_en             (send_en),
        .send_cmd_content    (send_cmd_content),
        .sd_cmd_sending      (sd_cmd_sending),
        .receive_en          (receive_en),
        .R2_response         (R2_response),
        .sd_receive_finished (sd_receive_finished),
        .crc_response_err    (crc_response_err),
        .response            (response),
        .done                (done),
        .status              (status),
        .resp_out            (resp_out),
        .card_status         (card_status),
        .retry_cnt           (retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           status;
        logic [31:0]  card;
        int           retry;
        int           sends;
        logic [126:0] resp;
        logic [37:0]  first;
        logic [37:0]  last;
        int           delta;
        int           gap;
        bit           rx;
        bit           r2;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // card model configuration
    logic [5:0]   rsp_idx_cfg;
    logic [31:0]  rsp_stat_cfg;
    logic [31:0]  app_stat_cfg;
    logic [87:0]  low_cfg;
    bit           crc_cfg, silent_cfg, abort_cfg;
    logic [126:0] exp_resp;
    logic [31:0]  exp_card;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(int st, logic [31:0] card, int rt, int ns, logic [126:0] rs,
                                logic [37:0] f, logic [37:0] l, int dl, int gp, bit rx, bit r2);
        exp_t e;
        e.status = st; e.card = card; e.retry = rt; e.sends = ns; e.resp = rs;
        e.first = f; e.last = l; e.delta = dl; e.gap = gp; e.rx = rx; e.r2 = r2;
        return e;
    endfunction

    // Drives one request, plays the sender/card, then scores the result against sb.
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic app,
                           input logic [1:0] rt, input logic [15:0] rca_v);
        exp_t        e;
        int          cyc, busy, cd, done_t;
        int          st[$];
        logic [37:0] sc[$];
        logic [37:0] last_c;
        bit          rx, r2, got_done;
        cyc = 0; busy = 0; cd = 0; done_t = -1; rx = 0; r2 = 0; last_c = '0;
        req_index = idx; req_arg = arg; req_app = app; req_rtype = rt; rca = rca_v;
        req_valid = 1'b1;
        chk("req_ready_idle", 128'(req_ready), 128'(1));
        while (cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0; sd_receive_finished = 1'b0; abort = 1'b0; crc_response_err = 1'b0;
            sd_cmd_sending = (busy > 0);
            if (busy > 0) busy--;
            rx |= receive_en;
            r2 |= R2_response;
            if (done) begin
                done_t = cyc;
                break;
            end
            if (send_en) begin
                st.push_back(cyc);
                sc.push_back(send_cmd_content);
                last_c = send_cmd_content;
                busy = 2;
                sd_cmd_sending = 1'b1;
                cd = 3;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0 && !silent_cfg) begin
                    if (last_c[37:32] == 6'd55) begin
                        response = {1'b0, 6'd55, app_stat_cfg, ~low_cfg};
                    end else begin
                        response = {1'b0, rsp_idx_cfg, rsp_stat_cfg, low_cfg};
                        crc_response_err = crc_cfg;
                    end
                    sd_receive_finished = 1'b1;
                    abort = abort_cfg;
                end
            end
        end
        e = sb.pop_front();
        got_done = (done_t >= 0);
        chk("done_seen", 128'(got_done), 128'(1));
        chk("status", 128'(status), 128'(e.status));
        chk("card_status", 128'(card_status), 128'(e.card));
        chk("retry_cnt", 128'(retry_cnt), 128'(e.retry));
        chk("resp_out", 128'(resp_out), 128'(e.resp));
        chk("n_send", 128'(st.size()), 128'(e.sends));
        chk("receive_en", 128'(rx), 128'(e.rx));
        chk("R2_response", 128'(r2), 128'(e.r2));
        if (st.size() > 0) begin
            chk("first_send_cyc", 128'(st[0]), 128'(1));
            chk("first_send", 128'(sc[0]), 128'(e.first));
            chk("last_send", 128'(last_c), 128'(e.last));
            chk("done_delta", 128'(done_t - st[st.size()-1]), 128'(e.delta));
        end
        for (int i = 1; i < st.size(); i++) begin
            chk("send_gap", 128'(st[i] - st[i-1]), 128'(e.gap));
        end
        @(negedge clk);
        chk("done_pulse", 128'(done), 128'(0));
        chk("ready_after", 128'(req_ready), 128'(1));
    endtask

    initial begin
        int w, ndone;
        crc_cfg = 0; silent_cfg = 0; abort_cfg = 0;
        rsp_idx_cfg = '0; rsp_stat_cfg = '0; app_stat_cfg = '0; low_cfg = '0;

        // reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 128'(req_ready), 128'(1));
        chk("rst_send_en", 128'(send_en), 128'(0));
        chk("rst_content", 128'(send_cmd_content), 128'(0));
        chk("rst_receive_en", 128'(receive_en), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_status", 128'(status), 128'(0));
        chk("rst_card", 128'(card_status), 128'(0));
        chk("rst_resp", 128'(resp_out), 128'(0));
        chk("rst_retry", 128'(retry_cnt), 128'(0));

        // CMD7 R1 success
        rsp_idx_cfg = 6'd7; rsp_stat_cfg = 32'h0000_0700; low_cfg = 88'h11_2233_4455_6677_8899_AABB;
        exp_resp = {1'b0, 6'd7, 32'h0000_0700, low_cfg}; exp_card = 32'h0000_0700;
        sb.push_back(mk(0, exp_card, 0, 1, exp_resp, {CMD7, 32'h1234_0000}, {CMD7, 32'h1234_0000}, 5, 0, 1, 0));
        run_cmd(CMD7, 32'h1234_0000, 1'b0, RT_R1, 16'h0000);

        // ACMD41: CMD55 then R3 with a CRC flag that must be ignored
        app_stat_cfg = 32'h0000_0120; rsp_idx_cfg = 6'h3F; rsp_stat_cfg = 32'h80FF_8000; crc_cfg = 1;
        low_cfg = 88'hCAFE_F00D_0123_4567_89AB_CD;
        exp_resp = {1'b0, 6'h3F, 32'h80FF_8000, low_cfg}; exp_card = 32'h0000_0120;
        sb.push_back(mk(0, exp_card, 0, 2, exp_resp, {CMD55, 32'h0}, {ACMD41, 32'h40FF_8000}, 5, 5, 1, 0));
        run_cmd(ACMD41, 32'h40FF_8000, 1'b1, RT_R3, 16'h0000);
        crc_cfg = 0;

        // APP phase without APP_CMD set in the card status, rca placed in CMD55
        app_stat_cfg = 32'h0000_0100; low_cfg = 88'h0F_0E0D_0C0B_0A09_0807_0605;
        exp_resp = {1'b0, 6'd55, 32'h0000_0100, ~low_cfg}; exp_card = 32'h0000_0100;
        sb.push_back(mk(5, exp_card, 0, 1, exp_resp, {CMD55, 16'hBEEF, 16'h0}, {CMD55, 16'hBEEF, 16'h0}, 5, 0, 1, 0));
        run_cmd(6'd6, 32'h0000_0002, 1'b1, RT_R1, 16'hBEEF);

        // CMD2 R2 with CRC error every attempt
        rsp_idx_cfg = 6'h3F; rsp_stat_cfg = 32'h1111_2222; crc_cfg = 1; low_cfg = 88'hDE_ADBE_EF00_1122_3344_5566;
        exp_resp = {1'b0, 6'h3F, 32'h1111_2222, low_cfg};
        sb.push_back(mk(1, exp_card, 3, 4, exp_resp, {CMD2, 32'h0}, {CMD2, 32'h0}, 5, 5, 1, 1));
        run_cmd(CMD2, 32'h0, 1'b0, RT_R2, 16'h0000);
        crc_cfg = 0;

        // CMD9 with no response: timeout on every attempt
        silent_cfg = 1;
        sb.push_back(mk(2, exp_card, 3, 4, exp_resp, {CMD9, 32'hBEEF_0000}, {CMD9, 32'hBEEF_0000}, TO + 1, TO + 1, 1, 1));
        run_cmd(CMD9, 32'hBEEF_0000, 1'b0, RT_R2, 16'h0000);
        silent_cfg = 0;

        // R1 with card-status bit 31 set
        rsp_idx_cfg = CMD13; rsp_stat_cfg = 32'h8000_0900; low_cfg = 88'h77_6655_4433_2211_0099_8877;
        exp_resp = {1'b0, CMD13, 32'h8000_0900, low_cfg}; exp_card = 32'h8000_0900;
        sb.push_back(mk(4, exp_card, 0, 1, exp_resp, {CMD13, 32'hBEEF_0000}, {CMD13, 32'hBEEF_0000}, 5, 0, 1, 0));
        run_cmd(CMD13, 32'hBEEF_0000, 1'b0, RT_R1, 16'h0000);

        // R1 with wrong index
        rsp_idx_cfg = 6'd5; rsp_stat_cfg = 32'h0000_0700; low_cfg = 88'h5A_5A5A_5A5A_5A5A_5A5A_5A5A;
        exp_resp = {1'b0, 6'd5, 32'h0000_0700, low_cfg}; exp_card = 32'h0000_0700;
        sb.push_back(mk(3, exp_card, 0, 1, exp_resp, {CMD7, 32'h1234_0000}, {CMD7, 32'h1234_0000}, 5, 0, 1, 0));
        run_cmd(CMD7, 32'h1234_0000, 1'b0, RT_R1, 16'h0000);

        // No-response command completes when the sender goes idle
        silent_cfg = 1;
        sb.push_back(mk(0, exp_card, 0, 1, exp_resp, {CMD0, 32'h0}, {CMD0, 32'h0}, 4, 0, 0, 0));
        run_cmd(CMD0, 32'h0, 1'b0, RT_NONE, 16'h0000);
        silent_cfg = 0;

        // Abort coincident with the response: response discarded
        rsp_idx_cfg = 6'd7; rsp_stat_cfg = 32'h0000_0900; low_cfg = 88'hAB_CDEF_0123_4567_89AB_CDEF; abort_cfg = 1;
        sb.push_back(mk(6, exp_card, 0, 1, exp_resp, {CMD7, 32'h1234_0000}, {CMD7, 32'h1234_0000}, 4, 0, 1, 0));
        run_cmd(CMD7, 32'h1234_0000, 1'b0, RT_R1, 16'h0000);
        abort_cfg = 0;

        // Abort in IDLE does nothing
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_ready", 128'(req_ready), 128'(1));
        chk("abort_idle_done", 128'(done), 128'(0));

        // Reset during CMD_WAIT
        req_index = CMD7; req_arg = 32'h1234_0000; req_app = 1'b0; req_rtype = RT_R1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while (!receive_en && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("reached_wait", 128'(receive_en), 128'(1));
        reset = 1'b1;
        #1;
        chk("midrst_ready", 128'(req_ready), 128'(1));
        chk("midrst_receive_en", 128'(receive_en), 128'(0));
        chk("midrst_card", 128'(card_status), 128'(0));
        chk("midrst_resp", 128'(resp_out), 128'(0));
        chk("midrst_status", 128'(status), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", 128'(ndone), 128'(0));
        chk("midrst_ready_after", 128'(req_ready), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
